// File: rtl/seven_seg_pkg.sv
// Shared types, constants and the hex-to-segment table for the seven-segment scanner.
// Segment words are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    typedef logic [1:0] digit_idx_t;
    typedef logic [6:0] seg_t;

    localparam seg_t       SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    function automatic seg_t hex_to_seg_f(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low segment decoder.
// Latency: 0 cycles; no backpressure, pure function of the input.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex_to_seg_f(nibble);

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed common-anode driver with shadow/active value registers and per-slot blanking.
// Latency: outputs registered, 1 cycle behind scan state; no backpressure, load is a fire-and-forget strobe.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100_000,
    parameter int BLANK_TICKS     = 1_000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
    output logic [3:0]  anodes,
    output seg_t        segments,
    output logic        dp,
    output logic        frame_start
);

    localparam int CW = $clog2(TICKS_PER_DIGIT);
    typedef logic [CW-1:0] cnt_t;

    cnt_t        cnt;
    digit_idx_t  dig;
    logic        pending;
    logic [15:0] shd_value, act_value;
    logic [3:0]  shd_dp, act_dp;
    logic [3:0]  shd_blank, act_blank;

    logic        wrap;
    logic        swap;
    logic [3:0]  an_nxt;
    seg_t        seg_dec;
    seg_t        seg_nxt;
    logic        dp_nxt;

    assign wrap = (cnt == cnt_t'(TICKS_PER_DIGIT - 1));
    assign swap = wrap && (dig == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            dig       <= '0;
            pending   <= 1'b0;
            shd_value <= '0;
            shd_dp    <= '0;
            shd_blank <= '0;
            act_value <= '0;
            act_dp    <= '0;
            act_blank <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                dig <= dig + 1'b1;
            end
            // Active reads the pre-edge shadow, so a load landing on the swap edge waits a frame.
            if (swap && pending) begin
                act_value <= shd_value;
                act_dp    <= shd_dp;
                act_blank <= shd_blank;
            end
            if (load) begin
                shd_value <= value;
                shd_dp    <= dp_in;
                shd_blank <= blank_in;
                pending   <= 1'b1;
            end else if (swap) begin
                pending   <= 1'b0;
            end
        end
    end

    hex_to_seg u_dec (
        .nibble (act_value[{dig, 2'b00} +: 4]),
        .seg    (seg_dec)
    );

    always_comb begin
        an_nxt = AN_OFF;
        if (cnt >= cnt_t'(BLANK_TICKS) && !act_blank[dig]) begin
            an_nxt[dig] = 1'b0;
        end
        seg_nxt = (an_nxt == AN_OFF) ? SEG_OFF : seg_dec;
        dp_nxt  = (an_nxt == AN_OFF) ? 1'b1 : ~act_dp[dig];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anodes      <= AN_OFF;
            segments    <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            anodes      <= an_nxt;
            segments    <= seg_nxt;
            dp          <= dp_nxt;
            frame_start <= swap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with TICKS_PER_DIGIT=10, BLANK_TICKS=2.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int passed = 0;
    int nframe;

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seven_seg_scan #(.TICKS_PER_DIGIT(10), .BLANK_TICKS(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .load        (load),
        .anodes      (anodes),
        .segments    (segments),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle load, then scrambles the data inputs to prove they are only sampled on load.
    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] blv);
        value    = v;
        dp_in    = dpv;
        blank_in = blv;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
        value    = 16'hDEAD;
        dp_in    = 4'hF;
        blank_in = 4'hF;
    endtask

    task automatic wait_frame(output int n);
        logic found;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 200 && !found; i++) begin
            step(1);
            if (frame_start) begin
                found = 1'b1;
                n = i;
            end
        end
        chk("frame_start_seen", 16'(found), 16'd1);
    endtask

    // Called on the frame_start sample; checks the 40 output cycles of the following frame.
    task automatic scan_frame(input string tag, input logic [15:0] v, input logic [3:0] dpv,
                              input logic [3:0] blv);
        logic       on;
        logic [3:0] one;
        logic [3:0] nib;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        one = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            for (int j = 1; j <= 10; j++) begin
                step(1);
                nib     = v[4*s +: 4];
                on      = (j >= 3) && !blv[s];
                exp_an  = on ? ~(one << s) : 4'hF;
                exp_seg = on ? seg_tbl[nib] : 7'h7F;
                exp_dp  = on ? ~dpv[s] : 1'b1;
                chk($sformatf("%s an d%0d c%0d", tag, s, j), 16'(anodes), 16'(exp_an));
                chk($sformatf("%s seg d%0d c%0d", tag, s, j), 16'(segments), 16'(exp_seg));
                chk($sformatf("%s dp d%0d c%0d", tag, s, j), 16'(dp), 16'(exp_dp));
                chk($sformatf("%s fs d%0d c%0d", tag, s, j), 16'(frame_start),
                    16'((s == 3) && (j == 10)));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        value    = '0;
        dp_in    = '0;
        blank_in = '0;
        load     = 1'b0;
        step(3);
        chk("rst anodes", 16'(anodes), 16'hF);
        chk("rst segments", 16'(segments), 16'h7F);
        chk("rst dp", 16'(dp), 16'd1);
        chk("rst frame_start", 16'(frame_start), 16'd0);

        reset = 1'b0;
        wait_frame(nframe);
        chk("first frame latency", 16'(nframe), 16'd40);
        // Active is still zero: every digit shows '0'.
        scan_frame("zero", 16'h0000, 4'h0, 4'h0);

        do_load(16'h1234, 4'b0000, 4'b0000);
        wait_frame(nframe);
        scan_frame("1234", 16'h1234, 4'b0000, 4'b0000);

        do_load(16'h8888, 4'b0100, 4'b0001);
        wait_frame(nframe);
        scan_frame("8888", 16'h8888, 4'b0100, 4'b0001);

        // A then B in one frame, then C exactly on the swap edge.
        step(5);
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        step(5);
        do_load(16'h5B07, 4'b0010, 4'b0000);
        step(27);
        do_load(16'hC3E9, 4'b1000, 4'b0000);
        chk("swap edge fs", 16'(frame_start), 16'd1);
        scan_frame("B", 16'h5B07, 4'b0010, 4'b0000);
        scan_frame("C1", 16'hC3E9, 4'b1000, 4'b0000);
        scan_frame("C2", 16'hC3E9, 4'b1000, 4'b0000);
        scan_frame("C3", 16'hC3E9, 4'b1000, 4'b0000);

        for (int n = 0; n < 16; n++) begin
            do_load(16'(n), 4'b0000, 4'b0000);
            wait_frame(nframe);
            step(3);
            chk($sformatf("sweep %0d anodes", n), 16'(anodes), 16'hE);
            chk($sformatf("sweep %0d segments", n), 16'(segments), 16'(seg_tbl[n]));
        end

        // Mid-slot async reset with a load still pending.
        do_load(16'hFFFF, 4'hF, 4'h0);
        step(13);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst anodes", 16'(anodes), 16'hF);
        chk("midrst segments", 16'(segments), 16'h7F);
        chk("midrst dp", 16'(dp), 16'd1);
        chk("midrst frame_start", 16'(frame_start), 16'd0);
        step(2);
        reset = 1'b0;
        wait_frame(nframe);
        chk("post reset latency", 16'(nframe), 16'd40);
        scan_frame("discard", 16'h0000, 4'h0, 4'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
